// File: rtl/aes_subkey_arbiter_if.sv
// Key-load and round-key read bus shared by key expansion, the encrypt core and the decrypt core.
// The arbiter sits on the slave modport; the environment drives the master side.
interface aes_subkey_arbiter_if #(
  parameter int unsigned KW = 128,
  parameter int unsigned AW = 4
);
  logic [1:0]    key_len;
  logic          load_start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [KW-1:0] wr_data;
  logic          load_done;
  logic          key_loaded;
  logic          load_err;

  logic          enc_req;
  logic [AW-1:0] enc_addr;
  logic          dec_req;
  logic [AW-1:0] dec_addr;
  logic [KW-1:0] subkey;
  logic          enc_valid;
  logic          dec_valid;
  logic          enc_err;
  logic          dec_err;

  modport slave (
    input  key_len, load_start, wr_en, wr_addr, wr_data, load_done,
    input  enc_req, enc_addr, dec_req, dec_addr,
    output key_loaded, load_err, subkey, enc_valid, dec_valid, enc_err, dec_err
  );

  modport master (
    output key_len, load_start, wr_en, wr_addr, wr_data, load_done,
    output enc_req, enc_addr, dec_req, dec_addr,
    input  key_loaded, load_err, subkey, enc_valid, dec_valid, enc_err, dec_err
  );
endinterface

// File: rtl/aes_subkey_arbiter.sv
// Round-key store for AES-128/192/256 with a round-robin, registered read port shared by the
// encrypt and decrypt cores.
module aes_subkey_arbiter #(
  parameter int unsigned NKEYS = 15,
  parameter int unsigned KW    = 128,
  parameter int unsigned AW    = 4
) (
  input logic                  clk,
  input logic                  reset,
  aes_subkey_arbiter_if.slave  bus
);

  localparam logic [AW-1:0] LastIdx = AW'(NKEYS - 1);

  typedef enum logic [0:0] {StIdle, StLoading} load_state_e;

  load_state_e    state_q, state_d;
  logic [AW-1:0]  nr_q, nr_d, nr_new;
  logic [NKEYS-1:0] mask_q, mask_d, need;
  logic           key_loaded_q, key_loaded_d;
  logic           load_err_q, load_err_d;
  logic           loading, wr_accept;
  logic [KW-1:0]  store_q [NKEYS];

  logic           rr_dec_q;
  logic           enc_elig, dec_elig, grant_enc, grant_dec;
  logic [AW-1:0]  gnt_addr;
  logic           gnt_in_range;
  logic           enc_valid_q, dec_valid_q, enc_err_q, dec_err_q;
  logic [KW-1:0]  subkey_q;

  always_comb begin
    unique case (bus.key_len)
      2'b01:   nr_new = AW'(10);
      2'b10:   nr_new = AW'(12);
      2'b11:   nr_new = AW'(14);
      default: nr_new = '0;
    endcase
  end

  always_comb begin
    need = '0;
    for (int i = 0; i < NKEYS; i++) begin
      need[i] = (AW'(i) <= nr_q);
    end
  end

  // Load FSM; load_start overrides everything and a same-cycle write joins the new load.
  always_comb begin
    state_d      = state_q;
    nr_d         = nr_q;
    mask_d       = mask_q;
    key_loaded_d = key_loaded_q;
    load_err_d   = 1'b0;
    wr_accept    = 1'b0;
    if (bus.load_start) begin
      state_d      = StLoading;
      nr_d         = nr_new;
      mask_d       = '0;
      key_loaded_d = 1'b0;
    end
    loading = bus.load_start || (state_q == StLoading);
    if (bus.wr_en) begin
      if (loading && (bus.wr_addr <= LastIdx)) begin
        wr_accept            = 1'b1;
        mask_d[bus.wr_addr]  = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end
    if ((state_q == StLoading) && bus.load_done && !bus.load_start) begin
      state_d = StIdle;
      if ((nr_q != '0) && ((mask_d & need) == need)) begin
        key_loaded_d = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end
  end

  // A requester is skipped for the cycle after its grant: it still shows the old address then.
  always_comb begin
    enc_elig     = bus.enc_req && key_loaded_q && !(enc_valid_q || enc_err_q);
    dec_elig     = bus.dec_req && key_loaded_q && !(dec_valid_q || dec_err_q);
    grant_enc    = enc_elig && (!dec_elig || !rr_dec_q);
    grant_dec    = dec_elig && !grant_enc;
    gnt_addr     = grant_enc ? bus.enc_addr : bus.dec_addr;
    gnt_in_range = (gnt_addr <= nr_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      nr_q         <= '0;
      mask_q       <= '0;
      key_loaded_q <= 1'b0;
      load_err_q   <= 1'b0;
      rr_dec_q     <= 1'b0;
      enc_valid_q  <= 1'b0;
      dec_valid_q  <= 1'b0;
      enc_err_q    <= 1'b0;
      dec_err_q    <= 1'b0;
      subkey_q     <= '0;
    end else begin
      state_q      <= state_d;
      nr_q         <= nr_d;
      mask_q       <= mask_d;
      key_loaded_q <= key_loaded_d;
      load_err_q   <= load_err_d;
      enc_valid_q  <= grant_enc && gnt_in_range;
      enc_err_q    <= grant_enc && !gnt_in_range;
      dec_valid_q  <= grant_dec && gnt_in_range;
      dec_err_q    <= grant_dec && !gnt_in_range;
      if (grant_enc || grant_dec) begin
        rr_dec_q <= grant_enc;
        subkey_q <= gnt_in_range ? store_q[gnt_addr] : '0;
      end
    end
  end

  // Key storage is deliberately not reset; key_loaded gates its use.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      store_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.key_loaded = key_loaded_q;
  assign bus.load_err   = load_err_q;
  assign bus.subkey     = subkey_q;
  assign bus.enc_valid  = enc_valid_q;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.enc_err    = enc_err_q;
  assign bus.dec_err    = dec_err_q;

endmodule

// File: tb/tb_aes_subkey_arbiter.sv
// Bench for aes_subkey_arbiter: directed scenarios plus random load/read traffic, all checked
// every cycle against a behavioural model of the key store and round-robin arbiter.
module tb_aes_subkey_arbiter;
  localparam int unsigned NKEYS = 15;
  localparam int unsigned KW    = 128;
  localparam int unsigned AW    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_subkey_arbiter_if #(.KW(KW), .AW(AW)) bus ();
  aes_subkey_arbiter #(.NKEYS(NKEYS), .KW(KW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [KW-1:0] kdata(input int i);
    logic [KW-1:0] ones;
    ones = {8{16'h1111}};
    return ones * KW'(i + 1);
  endfunction

  function automatic int nr_of(input logic [1:0] kl);
    case (kl)
      2'b01:   return 10;
      2'b10:   return 12;
      2'b11:   return 14;
      default: return 0;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  logic [KW-1:0] m_store [16];
  bit            m_written [16];
  int            m_nr;
  bit            m_loading, m_loaded;
  int            m_last;  // 0 = enc served last, 1 = dec served last
  logic          exp_ev, exp_dv, exp_ee, exp_de, exp_le;
  logic [KW-1:0] exp_sk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_nr = 0; m_loading = 0; m_loaded = 0; m_last = 1;
      foreach (m_written[i]) m_written[i] = 0;
      exp_ev = 0; exp_dv = 0; exp_ee = 0; exp_de = 0; exp_le = 0; exp_sk = '0;
    end else begin
      bit e_ok, d_ok, complete;
      int who, a;
      e_ok = bus.enc_req && m_loaded && !(exp_ev || exp_ee);
      d_ok = bus.dec_req && m_loaded && !(exp_dv || exp_de);
      who  = -1;
      if (e_ok && d_ok) who = (m_last == 0) ? 1 : 0;
      else if (e_ok)    who = 0;
      else if (d_ok)    who = 1;
      exp_ev = 0; exp_dv = 0; exp_ee = 0; exp_de = 0;
      if (who >= 0) begin
        a = (who == 0) ? int'(bus.enc_addr) : int'(bus.dec_addr);
        m_last = who;
        if (a > m_nr) begin
          exp_sk = '0;
          if (who == 0) exp_ee = 1; else exp_de = 1;
        end else begin
          exp_sk = m_store[a];
          if (who == 0) exp_ev = 1; else exp_dv = 1;
        end
      end
      exp_le = 0;
      if (bus.load_start) begin
        m_loading = 1; m_loaded = 0; m_nr = nr_of(bus.key_len);
        foreach (m_written[i]) m_written[i] = 0;
      end
      if (bus.wr_en) begin
        if (m_loading && int'(bus.wr_addr) < NKEYS) begin
          m_store[bus.wr_addr]   = bus.wr_data;
          m_written[bus.wr_addr] = 1;
        end else begin
          exp_le = 1;
        end
      end
      if (bus.load_done && m_loading && !bus.load_start) begin
        complete = (m_nr != 0);
        for (int r = 0; r <= m_nr; r++) if (!m_written[r]) complete = 0;
        if (complete) m_loaded = 1; else exp_le = 1;
        m_loading = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("key_loaded", bus.key_loaded, m_loaded);
      chk("load_err",   bus.load_err,   exp_le);
      chk("enc_valid",  bus.enc_valid,  exp_ev);
      chk("dec_valid",  bus.dec_valid,  exp_dv);
      chk("enc_err",    bus.enc_err,    exp_ee);
      chk("dec_err",    bus.dec_err,    exp_de);
      chk("subkey",     bus.subkey,     exp_sk);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.key_len = 2'b00; bus.load_start = 0; bus.wr_en = 0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.load_done = 0;
    bus.enc_req = 0; bus.enc_addr = '0; bus.dec_req = 0; bus.dec_addr = '0;
  endtask

  task automatic do_load(input logic [1:0] kl, input int last_idx);
    @(negedge clk);
    bus.load_start = 1; bus.key_len = kl;
    for (int i = 0; i <= last_idx; i++) begin
      @(negedge clk);
      bus.load_start = 0; bus.wr_en = 1; bus.wr_addr = AW'(i); bus.wr_data = kdata(i);
    end
    @(negedge clk);
    bus.load_start = 0; bus.wr_en = 0; bus.load_done = 1;
    @(negedge clk);
    bus.load_done = 0;
  endtask

  typedef struct {
    int            kind;  // 0 start, 1 write, 2 done
    logic [1:0]    kl;
    int            addr;
    logic [KW-1:0] data;
  } op_t;
  op_t plan[$];

  task automatic build_plan();
    op_t o;
    int  nr, n, t;
    int  idx [15];
    o.kl = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    o.kind = 0; o.addr = 0; o.data = '0;
    plan.push_back(o);
    nr = nr_of(o.kl);
    n  = (nr == 0) ? 11 : nr + 1;
    for (int i = 0; i < n; i++) idx[i] = i;
    for (int i = n - 1; i > 0; i--) begin
      int j;
      j = $urandom_range(0, i);
      t = idx[i]; idx[i] = idx[j]; idx[j] = t;
    end
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 19) != 0) begin
        o.kind = 1; o.addr = idx[i];
        o.data = {$urandom, $urandom, $urandom, $urandom};
        plan.push_back(o);
      end
      if ($urandom_range(0, 19) == 0) begin
        o.kind = 1; o.addr = 15; o.data = '1;
        plan.push_back(o);
      end
    end
    o.kind = 2;
    plan.push_back(o);
  endtask

  task automatic step_requesters();
    if (!bus.enc_req || bus.enc_valid || bus.enc_err) begin
      bus.enc_req = ($urandom_range(0, 3) != 0); bus.enc_addr = AW'($urandom_range(0, 15));
    end else if ($urandom_range(0, 15) == 0) begin
      bus.enc_req = 0;
    end
    if (!bus.dec_req || bus.dec_valid || bus.dec_err) begin
      bus.dec_req = ($urandom_range(0, 3) != 0); bus.dec_addr = AW'($urandom_range(0, 15));
    end else if ($urandom_range(0, 15) == 0) begin
      bus.dec_req = 0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ne, nd, prev;
    idle_inputs();
    #1 reset = 0;
    repeat (3) @(negedge clk);
    #2 reset = 1;
    @(negedge clk);
    chk("reset key_loaded", bus.key_loaded, 1'b0);
    chk("reset subkey", bus.subkey, '0);

    // 1: AES-128 load and a decrypt read of entry 10
    do_load(2'b01, 10);
    chk("t1 key_loaded", bus.key_loaded, 1'b1);
    chk("t1 load_err", bus.load_err, 1'b0);
    bus.dec_req = 1; bus.dec_addr = 4'd10;
    @(negedge clk);
    chk("t1 dec_valid", bus.dec_valid, 1'b1);
    chk("t1 model entry10", exp_sk, {8{16'hBBBB}});
    chk("t1 subkey entry10", bus.subkey, {8{16'hBBBB}});
    bus.dec_req = 0;

    // 2: incomplete AES-256 load
    do_load(2'b11, 13);
    chk("t2 load_err", bus.load_err, 1'b1);
    chk("t2 key_loaded", bus.key_loaded, 1'b0);
    bus.dec_req = 1; bus.dec_addr = 4'd3;
    repeat (5) begin
      @(negedge clk);
      chk("t2 no dec_valid", bus.dec_valid, 1'b0);
    end
    bus.dec_req = 0;

    // 3: contention, enc walks up, dec walks down
    do_load(2'b01, 10);
    bus.enc_req = 1; bus.enc_addr = 4'd0; bus.dec_req = 1; bus.dec_addr = 4'd10;
    ne = 0; nd = 0; prev = -1;
    for (int c = 0; c < 40 && (ne < 11 || nd < 11); c++) begin
      @(negedge clk);
      chk("t3 single valid", bus.enc_valid && bus.dec_valid, 1'b0);
      if (bus.enc_valid) begin
        chk("t3 enc key", bus.subkey, kdata(ne));
        chk("t3 enc alternates", prev != 0, 1'b1);
        prev = 0; ne++;
        bus.enc_addr = AW'(ne);
        if (ne == 11) bus.enc_req = 0;
      end else if (bus.dec_valid) begin
        chk("t3 dec key", bus.subkey, kdata(10 - nd));
        chk("t3 dec alternates", prev != 1, 1'b1);
        prev = 1; nd++;
        bus.dec_addr = AW'(10 - nd);
        if (nd == 11) bus.dec_req = 0;
      end
    end
    chk("t3 all served in budget", (ne == 11) && (nd == 11), 1'b1);
    bus.enc_req = 0; bus.dec_req = 0;

    // 4: range check under AES-192
    do_load(2'b10, 12);
    chk("t4 key_loaded", bus.key_loaded, 1'b1);
    bus.enc_req = 1; bus.enc_addr = 4'd13;
    @(negedge clk);
    chk("t4 enc_err", bus.enc_err, 1'b1);
    chk("t4 enc_valid", bus.enc_valid, 1'b0);
    chk("t4 subkey zero", bus.subkey, '0);
    bus.enc_req = 0; bus.dec_req = 1; bus.dec_addr = 4'd12;
    @(negedge clk);
    chk("t4 dec_valid", bus.dec_valid, 1'b1);
    chk("t4 subkey entry12", bus.subkey, {8{16'hDDDD}});
    bus.dec_req = 0;

    // 5: reload with a grant in flight, overwriting the entry being read
    @(negedge clk);
    bus.dec_req = 1; bus.dec_addr = 4'd5;
    bus.load_start = 1; bus.key_len = 2'b01;
    bus.wr_en = 1; bus.wr_addr = 4'd5; bus.wr_data = {8{16'hA5A5}};
    @(negedge clk);
    bus.load_start = 0; bus.wr_en = 0;
    chk("t5 dec_valid in flight", bus.dec_valid, 1'b1);
    chk("t5 old entry5", bus.subkey, {8{16'h6666}});
    chk("t5 key_loaded", bus.key_loaded, 1'b0);
    bus.dec_addr = 4'd6;
    repeat (4) begin
      @(negedge clk);
      chk("t5 waits", bus.dec_valid, 1'b0);
    end
    bus.load_done = 1;
    @(negedge clk);
    bus.load_done = 0; bus.dec_req = 0;
    chk("t5 short load_err", bus.load_err, 1'b1);
    do_load(2'b01, 10);
    bus.wr_en = 1; bus.wr_addr = 4'd3; bus.wr_data = {8{16'hDEAD}};
    @(negedge clk);
    bus.wr_en = 0;
    chk("t5 idle write load_err", bus.load_err, 1'b1);
    chk("t5 still loaded", bus.key_loaded, 1'b1);
    bus.dec_req = 1; bus.dec_addr = 4'd3;
    @(negedge clk);
    chk("t5 dec_valid entry3", bus.dec_valid, 1'b1);
    chk("t5 entry3 intact", bus.subkey, {8{16'h4444}});
    bus.dec_req = 0;

    // 6: asynchronous reset while a valid is showing
    @(negedge clk);
    bus.enc_req = 1; bus.enc_addr = 4'd2;
    @(posedge clk);
    #1 chk("t6 valid before reset", bus.enc_valid, 1'b1);
    #1 reset = 0;
    #1;
    chk("t6 enc_valid drops", bus.enc_valid, 1'b0);
    chk("t6 key_loaded drops", bus.key_loaded, 1'b0);
    chk("t6 subkey cleared", bus.subkey, '0);
    @(negedge clk);
    #2 reset = 1;
    repeat (4) begin
      @(negedge clk);
      chk("t6 no grant after reset", bus.enc_valid, 1'b0);
    end
    bus.enc_req = 0;
    do_load(2'b01, 10);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.load_start = 0; bus.wr_en = 0; bus.load_done = 0;
      if (plan.size() == 0 && $urandom_range(0, 29) == 0) build_plan();
      if (plan.size() > 0 && $urandom_range(0, 3) != 0) begin
        op_t o;
        o = plan.pop_front();
        case (o.kind)
          0: begin bus.load_start = 1; bus.key_len = o.kl; end
          1: begin bus.wr_en = 1; bus.wr_addr = AW'(o.addr); bus.wr_data = o.data; end
          default: bus.load_done = 1;
        endcase
      end else if ($urandom_range(0, 199) == 0) begin
        bus.wr_en = 1; bus.wr_addr = AW'($urandom_range(0, 15));
        bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
      step_requesters();
    end
    idle_inputs();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_subkey_arbiter.md
Name: aes_subkey_arbiter

Overview:
- Holds the expanded round-key schedule: 15 x 128-bit entries, enough for AES-256, rounds 0..14.
- Serves round keys to the encrypt core and the decrypt core over their existing subkey_addr / subkey / subkey_valid handshake.
- Loaded by the key-expansion block.
- Arbitrates round-robin between the two cores, one read per cycle, with a registered read path.

Parameters:
- NKEYS, 15, number of round-key entries.
- KW, 128, round-key width in bits.
- AW, 4, address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all control state immediately.
- key_len  in  2  01=AES-128 (Nr=10), 10=AES-192 (Nr=12), 11=AES-256 (Nr=14), 00=invalid; sampled on load_start.
- load_start  in  1  single-cycle pulse; begins a new key load.
- wr_en  in  1  write strobe from key expansion.
- wr_addr  in  AW  round-key index to write.
- wr_data  in  KW  round-key value.
- load_done  in  1  single-cycle pulse; ends the load.
- key_loaded  out  1  store holds a complete schedule.
- load_err  out  1  one-cycle pulse on a failed load or an illegal write.
- enc_req  in  1  encrypt core requests a key.
- enc_addr  in  AW  encrypt round index; held stable while enc_req=1 and until enc_valid.
- dec_req  in  1  decrypt core requests a key.
- dec_addr  in  AW  decrypt round index; same hold rule as enc_addr.
- subkey  out  KW  shared read data, meaningful only when a valid is high.
- enc_valid  out  1  one-cycle pulse: subkey is for the encrypt core.
- dec_valid  out  1  one-cycle pulse: subkey is for the decrypt core.
- enc_err  out  1  one-cycle pulse: encrypt request out of range.
- dec_err  out  1  one-cycle pulse: decrypt request out of range.

Behaviour:
- Reset (reset=0) clears:
  - key_loaded, load_err, all valid and err outputs, subkey=0.
  - nr=0, write mask=0, rr pointer=enc-preferred, load_active=0.
- Store contents are not reset. They are unusable while key_loaded=0.
- Load FSM, states IDLE / LOADING:
  - load_start in any state:
    - nr <- Nr(key_len), mask <- 0, key_loaded <- 0, go to LOADING.
    - If key_len=00: nr <- 0 and load completion will fail.
  - LOADING, wr_en=1, wr_addr<NKEYS: store[wr_addr] <- wr_data, mask[wr_addr] <- 1.
  - LOADING, wr_addr>=NKEYS: write dropped, load_err pulse.
  - LOADING, load_done:
    - If nr!=0 and mask[nr:0] is all ones: key_loaded <- 1.
    - Otherwise: load_err pulse and key_loaded stays 0.
    - Either way, go to IDLE.
  - wr_en in IDLE: ignored, load_err pulse. A loaded schedule is never corrupted.
  - Simultaneous load_start + wr_en: load_start wins; the write is also accepted into the new load.
  - Simultaneous load_start + load_done: load_start wins.
- Eligibility: requester X is eligible in cycle N when all of these hold:
  - X_req=1.
  - key_loaded=1.
  - No grant to X was issued in cycle N-1, so X_valid and X_err are 0 in cycle N. X updates its address on the valid edge, so it must not be re-granted while it still presents the old address.
- Arbitration:
  - At most one grant per cycle.
  - Only one eligible: grant it.
  - Both eligible: grant the requester not granted most recently.
  - The rr pointer updates only on a grant.
- Read latency 1:
  - A grant at edge N captures addr. subkey and X_valid are high during cycle N+1.
  - Other cycles: both valids 0; subkey holds its last value.
- Range check is at grant:
  - addr>nr: X_err pulses instead of X_valid, subkey <- 0.
  - The requester is still considered served for rr purposes.
- Throughput: two continuous requesters alternate, one key every cycle in total. A single requester gets one key every 2 cycles.
- load_start with a read in flight:
  - The grant captured before the edge completes with the old data.
  - No new grants until key_loaded returns to 1.
- A requester dropping req before its grant is simply not served. No stall or error.
- Async reset mid-transfer: any pending valid is cancelled immediately.

Test Plan:
1. Load AES-128: load_start key_len=01, write addr 0..10 with data 0x1111...*(i+1), load_done -> key_loaded=1 next cycle, load_err=0; dec_req addr=10 -> dec_valid one cycle later with subkey=0x...BBBB (entry 10).
2. Incomplete load: key_len=11, write 0..13 only, load_done -> load_err pulse, key_loaded=0; dec_req held -> no valid ever issued.
3. Contention: both req continuously; enc addr walks 0..10, dec addr walks 10..0 -> valids alternate enc, dec, enc...; each core receives the correct entry; no core is granted in its own valid cycle.
4. Range: AES-192 loaded, enc_addr=13 -> enc_err pulse, subkey=0, no enc_valid; dec_addr=12 in the next grant -> valid with entry 12.
5. Reload mid-traffic: load_start while a dec grant is in flight -> that dec_valid still arrives with old entry, key_loaded=0, later requests wait; write in IDLE -> load_err, store unchanged.
6. Assert reset=0 asynchronously between edges during a pending grant -> key_loaded, all valids and errs drop to 0 immediately; after release, nothing is granted until a new load completes.
